enc_cmd_seq: RTL and testbench

ENC_CMD_SEQ -- requirements
Module: enc_cmd_seq

---
 rtl/enc_cmd_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_enc_cmd_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_cmd_seq.sv
// ENC28J60 control-register command sequencer.
// Buffers commands in a small FIFO and issues each one to the SPI driver.
// Before a banked command it inserts a BFC/BFS pair on ECON1 when the
// register bank has to change.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a queued command; pops the FIFO head when present
// DECIDE   | chooses between direct issue and a bank switch
// BFC_REQ  | start pulse for BFC ECON1,0x03 (clear bank select bits)
// BFC_WAIT | waiting for the driver to finish the BFC
// BFS_REQ  | start pulse for BFS ECON1,bank (set bank select bits)
// BFS_WAIT | waiting for the driver to finish the BFS
// CMD_REQ  | start pulse for the command itself
// CMD_WAIT | waiting for the driver to finish the command
module enc_cmd_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_opcode,
    input  logic [4:0] cmd_addr,
    input  logic [1:0] cmd_bank,
    input  logic [7:0] cmd_data,
    output logic       run_req,
    output logic [2:0] opcode,
    output logic [4:0] write_addr,
    output logic [7:0] write_data,
    input  logic       end_flag,
    output logic       busy,
    output logic       err_timeout
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W:0]   PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT);

    localparam logic [2:0] OP_WCR = 3'b010;
    localparam logic [2:0] OP_BFS = 3'b100;
    localparam logic [2:0] OP_BFC = 3'b101;
    localparam logic [2:0] OP_SRC = 3'b111;

    // ECON1 lives at 0x1F in every bank; 0x1B..0x1F are common to all banks
    localparam logic [4:0] ECON1_ADDR  = 5'h1F;
    localparam logic [4:0] COMMON_BASE = 5'h1B;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] addr;
        logic [1:0] bank;
        logic [7:0] data;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        BFC_REQ,
        BFC_WAIT,
        BFS_REQ,
        BFS_WAIT,
        CMD_REQ,
        CMD_WAIT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    cmd_t             cur;
    logic [1:0]       cur_bank;
    logic             bank_valid;
    logic [CNT_W-1:0] wait_cnt;
    logic             done;
    logic             timeout_hit;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign cmd_ready  = !rst && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign busy       = (state != IDLE) || !fifo_empty;

    // command storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= '{op: cmd_opcode, addr: cmd_addr,
                                             bank: cmd_bank, data: cmd_data};
        end
    end

    // FIFO pointers and the current-command register loaded on pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cur    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                cur    <= fifo_mem[rd_ptr[PTR_W-1:0]];
            end
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state, start pulse, completion and timeout decode
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        run_req     = 1'b0;
        done        = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                if (cur.addr >= COMMON_BASE || cur.op == OP_SRC) begin
                    state_nxt = CMD_REQ;
                end else if (bank_valid && cur.bank == cur_bank) begin
                    state_nxt = CMD_REQ;
                end else begin
                    state_nxt = BFC_REQ;
                end
            end
            BFC_REQ: begin
                run_req   = 1'b1;
                state_nxt = BFC_WAIT;
            end
            BFS_REQ: begin
                run_req   = 1'b1;
                state_nxt = BFS_WAIT;
            end
            CMD_REQ: begin
                run_req   = 1'b1;
                state_nxt = CMD_WAIT;
            end
            BFC_WAIT, BFS_WAIT, CMD_WAIT: begin
                // completion wins over the timeout on the terminal cycle
                if (end_flag) begin
                    done = 1'b1;
                    if (state == CMD_WAIT) begin
                        state_nxt = IDLE;
                    end else if (state == BFC_WAIT && cur.bank != 2'd0) begin
                        state_nxt = BFS_REQ;
                    end else begin
                        state_nxt = CMD_REQ;
                    end
                end else if (wait_cnt == CNT_TC) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // driver fields are loaded on entry to a request state and held through the wait
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode     <= '0;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            case (state_nxt)
                BFC_REQ: begin
                    opcode     <= OP_BFC;
                    write_addr <= ECON1_ADDR;
                    write_data <= 8'h03;
                end
                BFS_REQ: begin
                    opcode     <= OP_BFS;
                    write_addr <= ECON1_ADDR;
                    write_data <= {6'b0, cur.bank};
                end
                CMD_REQ: begin
                    opcode     <= cur.op;
                    write_addr <= cur.addr;
                    write_data <= cur.data;
                end
                default: ;
            endcase
        end
    end

    // wait counter: zeroed while requesting, counts cycles spent waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == BFC_REQ || state == BFS_REQ || state == CMD_REQ) begin
            wait_cnt <= '0;
        end else if (state == BFC_WAIT || state == BFS_WAIT || state == CMD_WAIT) begin
            wait_cnt <= wait_cnt + CNT_ONE;
        end
    end

    // bank tracking and the sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_bank    <= 2'd0;
            bank_valid  <= 1'b0;
            err_timeout <= 1'b0;
        end else if (timeout_hit) begin
            // the bank select bits may have been half-written, so distrust them
            err_timeout <= 1'b1;
            bank_valid  <= 1'b0;
        end else if (done) begin
            case (state)
                BFC_WAIT: begin
                    if (cur.bank == 2'd0) begin
                        cur_bank   <= 2'd0;
                        bank_valid <= 1'b1;
                    end
                end
                BFS_WAIT: begin
                    cur_bank   <= cur.bank;
                    bank_valid <= 1'b1;
                end
                CMD_WAIT: begin
                    if (cur.op == OP_SRC) begin
                        cur_bank   <= 2'd0;
                        bank_valid <= 1'b1;
                    end else if (cur.addr == ECON1_ADDR &&
                                 (cur.op == OP_WCR || cur.op == OP_BFS || cur.op == OP_BFC)) begin
                        bank_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enc_cmd_seq.sv
// Scoreboard bench for enc_cmd_seq: the main flow queues the expected driver
// transactions, a monitor compares them as run_req pulses appear, and a
// responder model plays the SPI driver with a programmable end_flag delay.
module tb_enc_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_opcode;
    logic [4:0] cmd_addr;
    logic [1:0] cmd_bank;
    logic [7:0] cmd_data;
    logic       run_req;
    logic [2:0] opcode;
    logic [4:0] write_addr;
    logic [7:0] write_data;
    logic       end_flag;
    logic       busy;
    logic       err_timeout;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    bit          resp_en  = 1'b1;
    int          resp_dly = 3;

    enc_cmd_seq #(.FIFO_DEPTH(4), .TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_addr   (cmd_addr),
        .cmd_bank   (cmd_bank),
        .cmd_data   (cmd_data),
        .run_req    (run_req),
        .opcode     (opcode),
        .write_addr (write_addr),
        .write_data (write_data),
        .end_flag   (end_flag),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input logic [2:0] op, input logic [4:0] a, input logic [7:0] d);
        exp_q.push_back({op, a, d});
    endtask

    task automatic push(input logic [2:0] op, input logic [4:0] a,
                        input logic [1:0] b, input logic [7:0] d);
        int n = 0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_addr   = a;
        cmd_bank   = b;
        cmd_data   = d;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("push_accept", cmd_ready, 1);
        end else begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        @(negedge clk);
        while (busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, busy, 0);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    // driver model: answers each start pulse with end_flag resp_dly cycles later
    initial begin
        end_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (run_req && !rst && resp_en) begin
                repeat (resp_dly) @(posedge clk);
                #1 end_flag = 1'b1;
                @(posedge clk);
                #1 end_flag = 1'b0;
            end
        end
    end

    // monitor: each start pulse must match the scoreboard head; fields must hold to end_flag
    logic [15:0] last_txn;
    bit          last_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            last_valid = 1'b0;
        end else begin
            if (run_req) begin
                chk("run_req_vs_end_flag", end_flag, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_run_req: got %0h expected none",
                             {opcode, write_addr, write_data});
                end else begin
                    chk("run_req_fields", {opcode, write_addr, write_data}, exp_q.pop_front());
                end
                last_txn   = {opcode, write_addr, write_data};
                last_valid = 1'b1;
            end else if (end_flag && last_valid) begin
                chk("held_at_end_flag", {opcode, write_addr, write_data}, last_txn);
                last_valid = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_addr   = '0;
        cmd_bank   = '0;
        cmd_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_run_req", run_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_fields", {opcode, write_addr, write_data}, 0);
        rst = 1'b0;
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);

        // unknown bank: BFC, BFS, then the write
        expect_txn(3'b101, 5'h1F, 8'h03);
        expect_txn(3'b100, 5'h1F, 8'h02);
        expect_txn(3'b010, 5'h02, 8'hAA);
        push(3'b010, 5'h02, 2'd2, 8'hAA);
        wait_idle("first", 200);

        // same bank: direct issue
        expect_txn(3'b010, 5'h04, 8'h55);
        push(3'b010, 5'h04, 2'd2, 8'h55);
        wait_idle("same_bank", 100);

        // common register then SRC, then bank 0 with no switch
        expect_txn(3'b010, 5'h1C, 8'h11);
        expect_txn(3'b111, 5'h1F, 8'hFF);
        expect_txn(3'b010, 5'h05, 8'h33);
        push(3'b010, 5'h1C, 2'd3, 8'h11);
        push(3'b111, 5'h1F, 2'd0, 8'hFF);
        push(3'b010, 5'h05, 2'd0, 8'h33);
        wait_idle("src", 200);

        // bank 1 needs BFC+BFS; back to bank 0 needs only BFC
        expect_txn(3'b101, 5'h1F, 8'h03);
        expect_txn(3'b100, 5'h1F, 8'h01);
        expect_txn(3'b010, 5'h03, 8'h44);
        expect_txn(3'b101, 5'h1F, 8'h03);
        expect_txn(3'b010, 5'h06, 8'h66);
        push(3'b010, 5'h03, 2'd1, 8'h44);
        push(3'b010, 5'h06, 2'd0, 8'h66);
        wait_idle("bank_hop", 300);

        // BFS to ECON1 invalidates the bank; next bank-0 command re-clears
        expect_txn(3'b100, 5'h1F, 8'h01);
        expect_txn(3'b101, 5'h1F, 8'h03);
        expect_txn(3'b010, 5'h07, 8'h77);
        push(3'b100, 5'h1F, 2'd0, 8'h01);
        push(3'b010, 5'h07, 2'd0, 8'h77);
        wait_idle("econ1_write", 300);

        // five commands while the first is held: FIFO fills at four queued
        resp_dly = 20;
        for (int i = 0; i < 5; i++) begin
            logic [4:0] a;
            logic [7:0] d;
            a = 5'(8 + i);
            d = 8'((8 + i) * 16);
            expect_txn(3'b010, a, d);
        end
        for (int i = 0; i < 5; i++) begin
            push(3'b010, 5'(8 + i), 2'd0, 8'((8 + i) * 16));
        end
        chk("full_cmd_ready", cmd_ready, 0);
        chk("full_busy", busy, 1);
        wait_idle("fifo_full", 600);

        // end_flag on the terminal count still completes
        resp_dly = 256;
        expect_txn(3'b010, 5'h0D, 8'hD0);
        push(3'b010, 5'h0D, 2'd0, 8'hD0);
        wait_idle("tc_boundary", 400);
        chk("tc_boundary_err", err_timeout, 0);

        // one cycle later is a timeout; the late end_flag is ignored
        resp_dly = 257;
        expect_txn(3'b010, 5'h0E, 8'hE0);
        push(3'b010, 5'h0E, 2'd0, 8'hE0);
        wait_idle("timeout", 400);
        chk("timeout_err", err_timeout, 1);
        repeat (5) @(negedge clk);
        chk("timeout_after_late_end", busy, 0);

        // bank state was dropped by the timeout
        resp_dly = 2;
        expect_txn(3'b101, 5'h1F, 8'h03);
        expect_txn(3'b010, 5'h02, 8'h22);
        push(3'b010, 5'h02, 2'd0, 8'h22);
        wait_idle("after_timeout", 200);
        chk("err_sticky", err_timeout, 1);

        // reset in BFS_WAIT aborts and discards the queued command
        resp_dly = 50;
        expect_txn(3'b101, 5'h1F, 8'h03);
        expect_txn(3'b100, 5'h1F, 8'h03);
        push(3'b010, 5'h03, 2'd3, 8'h3C);
        push(3'b010, 5'h04, 2'd3, 8'h4C);
        n = 0;
        @(negedge clk);
        while (!(opcode == 3'b100 && !run_req) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bfs_wait", opcode, 3'b100);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_run_req", run_req, 0);
        chk("mid_rst_fields", {opcode, write_addr, write_data}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err_timeout, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_rel_ready", cmd_ready, 1);
        repeat (70) @(negedge clk);
        chk("late_end_ignored", busy, 0);
        chk("rst_scoreboard", exp_q.size(), 0);

        // reset forgot the bank: bank 0 command needs a BFC again
        resp_dly = 2;
        expect_txn(3'b101, 5'h1F, 8'h03);
        expect_txn(3'b010, 5'h05, 8'h50);
        push(3'b010, 5'h05, 2'd0, 8'h50);
        wait_idle("post_rst", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
